// File: rtl/datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_seq
//  Brief    : Self-sequencing datapath. It holds a register file, A/B/C
//             pipeline registers, a one-bit shifter, an ALU and a V/N/Z status
//             register. An internal FSM takes one instruction at a time over a
//             valid/ready handshake.
//  Options  : DATAPATH_SEQ_RDPORT_EN adds a second register-file read port.
//             LOADA and LOADB then merge into a single LOADAB state.
//  Revision : 1.0  initial release
// ============================================================================
module datapath_seq #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 5,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       mode,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic [1:0]       shift,
  input  logic [1:0]       aluop,
  input  logic             bsel_imm,
  input  logic [WIDTH-1:0] imm,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       status
);

  localparam logic [1:0] MODE_MOVI = 2'b00;
  localparam logic [1:0] MODE_MOVR = 2'b01;
  localparam logic [1:0] MODE_CMP  = 2'b11;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  // Keeps only the low IMM_W bits of the immediate when it is used as B operand.
  localparam logic [WIDTH-1:0] IMM_MASK = {WIDTH{1'b1}} >> (WIDTH - IMM_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADA  = 3'd1,
    S_LOADB  = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_LOADAB = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [2:0]       status_q, status_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  // Instruction fields captured at accept time.
  logic [1:0]       mode_q, mode_d;
  logic [RW-1:0]    rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [1:0]       shift_q, shift_d, aluop_q, aluop_d;
  logic             bsel_q, bsel_d;
  logic [WIDTH-1:0] imm_q, imm_d;

  // ALU signals.
  logic [WIDTH-1:0] b_shifted, b_op, a_op, b_eff, sum, alu_out;
  logic [1:0]       op_eff;
  logic             is_sub, alu_v;

  assign req_ready = (state_q == S_IDLE) && reset_n;
  assign done      = done_q;
  assign result    = c_q;
  assign status    = status_q;

  // Shifter and ALU: MOVR forces A to 0 and the operation to add.
  always_comb begin
    b_shifted = b_q;
    case (shift_q)
      2'b01:   b_shifted = {b_q[WIDTH-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_q[WIDTH-1:1]};
      2'b11:   b_shifted = {b_q[WIDTH-1], b_q[WIDTH-1:1]};
      default: b_shifted = b_q;
    endcase
    b_op   = bsel_q ? (imm_q & IMM_MASK) : b_shifted;
    a_op   = (mode_q == MODE_MOVR) ? '0 : a_q;
    op_eff = (mode_q == MODE_MOVR) ? OP_ADD : aluop_q;
    is_sub = (op_eff == OP_SUB);
    b_eff  = is_sub ? ~b_op : b_op;
    sum    = a_op + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    alu_v  = 1'b0;
    case (op_eff)
      OP_ADD, OP_SUB: begin
        alu_out = sum;
        alu_v   = (a_op[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_op[WIDTH-1]);
      end
      OP_AND:  alu_out = a_op & b_op;
      default: alu_out = ~b_op;
    endcase
  end

  // Next-state logic: sequencing, operand loads, execute and writeback.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    status_d = status_q;
    regs_d   = regs_q;
    mode_d   = mode_q;
    rd_d     = rd_q;
    rn_d     = rn_q;
    rm_d     = rm_q;
    shift_d  = shift_q;
    aluop_d  = aluop_q;
    bsel_d   = bsel_q;
    imm_d    = imm_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mode_d  = mode;
          rd_d    = rd;
          rn_d    = rn;
          rm_d    = rm;
          shift_d = shift;
          aluop_d = aluop;
          bsel_d  = bsel_imm;
          imm_d   = imm;
          case (mode)
            MODE_MOVI: state_d = S_WB;
            MODE_MOVR: state_d = S_LOADB;
`ifdef DATAPATH_SEQ_RDPORT_EN
            default:   state_d = S_LOADAB;
`else
            default:   state_d = S_LOADA;
`endif
          endcase
        end
      end
`ifdef DATAPATH_SEQ_RDPORT_EN
      S_LOADAB: begin
        a_d     = regs_q[rn_q];
        b_d     = regs_q[rm_q];
        state_d = S_EXEC;
      end
`else
      S_LOADA: begin
        a_d     = regs_q[rn_q];
        state_d = S_LOADB;
      end
`endif
      S_LOADB: begin
        b_d     = regs_q[rm_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        c_d      = alu_out;
        status_d = {alu_v, alu_out[WIDTH-1], (alu_out == '0)};
        if (mode_q == MODE_CMP) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        regs_d[rd_q] = (mode_q == MODE_MOVI) ? imm_q : c_q;
        done_d       = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and register-file flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      done_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      status_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      mode_q   <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      shift_q  <= '0;
      aluop_q  <= '0;
      bsel_q   <= 1'b0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      status_q <= status_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      mode_q   <= mode_d;
      rd_q     <= rd_d;
      rn_q     <= rn_d;
      rm_q     <= rm_d;
      shift_q  <= shift_d;
      aluop_q  <= aluop_d;
      bsel_q   <= bsel_d;
      imm_q    <= imm_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datapath_seq
//  Brief    : Directed, table-driven self-checking bench for datapath_seq.
//             Register contents are observed by MOVR Rx,Rx read-backs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_datapath_seq;

  localparam logic [1:0] MOVI = 2'b00, MOVR = 2'b01, ALU = 2'b10, CMP = 2'b11;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, AND = 2'b10, NOT = 2'b11;
`ifdef DATAPATH_SEQ_RDPORT_EN
  localparam int LAT_ALU = 3;
  localparam int LAT_CMP = 2;
`else
  localparam int LAT_ALU = 4;
  localparam int LAT_CMP = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n, req_valid, req_ready, bsel_imm, done;
  logic [1:0]  mode, shift, aluop;
  logic [2:0]  rd, rn, rm, status;
  logic [15:0] imm, result;

  int checks = 0;
  int errors = 0;

  datapath_seq dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .mode(mode), .rd(rd), .rn(rn), .rm(rm), .shift(shift), .aluop(aluop),
    .bsel_imm(bsel_imm), .imm(imm), .done(done), .result(result), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  rd, rn, rm;
    logic [1:0]  shift, aluop;
    logic        bsel;
    logic [15:0] imm;
    logic [15:0] res;
    logic [2:0]  st;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] m, logic [2:0] d, logic [2:0] n, logic [2:0] s,
                              logic [1:0] sh, logic [1:0] op, logic b, logic [15:0] im,
                              logic [15:0] r, logic [2:0] st, int lat);
    vec_t v;
    v.mode = m; v.rd = d; v.rn = n; v.rm = s; v.shift = sh; v.aluop = op;
    v.bsel = b; v.imm = im; v.res = r; v.st = st; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    mode = v.mode; rd = v.rd; rn = v.rn; rm = v.rm; shift = v.shift;
    aluop = v.aluop; bsel_imm = v.bsel; imm = v.imm;
  endtask

  // Scrambles request fields so any capture outside the accept edge shows up.
  task automatic scramble();
    mode = ~mode; rd = ~rd; rn = ~rn; rm = ~rm; shift = ~shift;
    aluop = ~aluop; bsel_imm = ~bsel_imm; imm = ~imm;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (!done && cycles < 20);
  endtask

  task automatic run_op(input string name, input vec_t v);
    int cyc;
    @(negedge clk);
    drive(v);
    req_valid = 1'b1;
    chk({name, " ready_idle"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    chk({name, " ready_busy"}, req_ready, 0);
    wait_done(cyc);
    chk({name, " latency"}, cyc, v.lat);
    chk({name, " result"}, result, v.res);
    chk({name, " status"}, status, v.st);
    chk({name, " ready_done"}, req_ready, 1);
    @(posedge clk); #1;
    chk({name, " done_pulse"}, done, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vec_t va, vb;
    // mode rd rn rm shift aluop bsel imm expected_result expected_status latency
    vecs.push_back(mk(MOVI, 3, 0, 0, 0, 0,   0, 16'd42,   16'd0,    3'b000, 1));
    vecs.push_back(mk(MOVI, 5, 0, 0, 0, 0,   0, 16'd13,   16'd0,    3'b000, 1));
    vecs.push_back(mk(ALU,  2, 3, 5, 0, ADD, 0, 16'd0,    16'd55,   3'b000, LAT_ALU));
    vecs.push_back(mk(MOVR, 2, 0, 2, 0, 0,   0, 16'd0,    16'd55,   3'b000, 3));
    vecs.push_back(mk(MOVR, 7, 0, 3, 1, 0,   0, 16'd0,    16'd84,   3'b000, 3));
    vecs.push_back(mk(MOVI, 1, 0, 0, 0, 0,   0, 16'h8000, 16'd84,   3'b000, 1));
    vecs.push_back(mk(MOVR, 6, 0, 1, 2, 0,   0, 16'd0,    16'h4000, 3'b000, 3));
    vecs.push_back(mk(MOVR, 6, 0, 1, 3, 0,   0, 16'd0,    16'hC000, 3'b010, 3));
    vecs.push_back(mk(MOVR, 6, 0, 1, 0, 0,   1, 16'hFFEA, 16'h000A, 3'b000, 3));
    vecs.push_back(mk(MOVI, 0, 0, 0, 0, 0,   0, 16'h7FFF, 16'h000A, 3'b000, 1));
    vecs.push_back(mk(MOVI, 4, 0, 0, 0, 0,   0, 16'h0001, 16'h000A, 3'b000, 1));
    vecs.push_back(mk(ALU,  6, 0, 4, 0, ADD, 0, 16'd0,    16'h8000, 3'b110, LAT_ALU));
    vecs.push_back(mk(CMP,  4, 4, 4, 0, SUB, 0, 16'd0,    16'h0000, 3'b001, LAT_CMP));
    vecs.push_back(mk(MOVR, 4, 0, 4, 0, 0,   0, 16'd0,    16'h0001, 3'b000, 3));
    vecs.push_back(mk(ALU,  6, 1, 4, 0, SUB, 0, 16'd0,    16'h7FFF, 3'b100, LAT_ALU));
    vecs.push_back(mk(ALU,  6, 3, 5, 0, AND, 0, 16'd0,    16'h0008, 3'b000, LAT_ALU));
    vecs.push_back(mk(ALU,  6, 3, 5, 0, NOT, 0, 16'd0,    16'hFFF2, 3'b010, LAT_ALU));
    vecs.push_back(mk(ALU,  6, 5, 3, 0, SUB, 0, 16'd0,    16'hFFE3, 3'b010, LAT_ALU));
    vecs.push_back(mk(ALU,  6, 3, 5, 1, ADD, 0, 16'd0,    16'h0044, 3'b000, LAT_ALU));
    vecs.push_back(mk(ALU,  3, 3, 3, 0, ADD, 0, 16'd0,    16'd84,   3'b000, LAT_ALU));
    vecs.push_back(mk(MOVR, 3, 0, 3, 0, 0,   0, 16'd0,    16'd84,   3'b000, 3));

    // Reset state.
    reset_n = 1'b0; req_valid = 1'b0;
    mode = '0; rd = '0; rn = '0; rm = '0; shift = '0; aluop = '0; bsel_imm = 1'b0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset result", result, 0);
    chk("reset status", status, 0);
    chk("reset done", done, 0);
    chk("reset ready_low", req_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("reset ready_high", req_ready, 1);

    for (int i = 0; i < vecs.size(); i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Back-to-back with req_valid held: ALU R6=R3+R5 (84+13), then MOVR R6,R6 LSL1.
    va = mk(ALU,  6, 3, 5, 0, ADD, 0, 16'd0, 16'd97,  3'b000, LAT_ALU);
    vb = mk(MOVR, 6, 0, 6, 1, 0,   0, 16'd0, 16'd194, 3'b000, 3);
    @(negedge clk);
    drive(va);
    req_valid = 1'b1;
    @(posedge clk); #1;
    drive(mk(MOVI, 7, 0, 0, 0, 0, 0, 16'h1234, 16'd0, 3'b000, 1));
    wait_done(cyc);
    chk("b2b A latency", cyc, LAT_ALU);
    chk("b2b A result", result, 16'd97);
    chk("b2b A ready", req_ready, 1);
    drive(vb);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    chk("b2b B done_low", done, 0);
    chk("b2b B ready_low", req_ready, 0);
    wait_done(cyc);
    chk("b2b B latency", cyc, 3);
    chk("b2b B result", result, 16'd194);
    run_op("b2b R7 readback", mk(MOVR, 7, 0, 7, 0, 0, 0, 16'd0, 16'd84, 3'b000, 3));

    // Reset during EXEC of ALU R5=R3+R5: abandoned, no done, everything cleared.
    @(negedge clk);
    drive(mk(ALU, 5, 3, 5, 0, ADD, 0, 16'd0, 16'd0, 3'b000, LAT_ALU));
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (LAT_ALU - 2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_exec ready_low", req_ready, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst_exec result", result, 0);
    chk("rst_exec status", status, 0);
    chk("rst_exec done", done, 0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rst_exec no_done%0d", k), done, 0);
    end
    run_op("rst_exec R5 readback", mk(MOVR, 5, 0, 5, 0, 0, 0, 16'd0, 16'd0, 3'b001, 3));
    run_op("rst_exec R3 readback", mk(MOVR, 3, 0, 3, 0, 0, 0, 16'd0, 16'd0, 3'b001, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
